// File: rtl/imc_program_sequencer.sv
// Program sequencer for the SRAM in-memory-compute array: fetches instructions,
// decodes WRITE/READ/IMC/NOP/END and holds the array strobes for a per-op cycle count.
`timescale 1ns/1ps
module imc_program_sequencer #(
  parameter int PC_W       = 6,
  parameter int WR_CYCLES  = 2,
  parameter int RD_CYCLES  = 2,
  parameter int IMC_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd_en,
  input  logic [31:0]     imem_data,
  input  logic            imem_valid,
  output logic [3:0]      address_input,
  output logic            en_dec,
  output logic            mem_en,
  output logic            imc_en,
  output logic            rw,
  output logic            Input_buffer_rd_en,
  output logic            Weight_buffer_rd_en,
  output logic            sram_data_rd_enable,
  output logic            busy,
  output logic            done,
  output logic            err_illegal,
  output logic [PC_W-1:0] pc
);

  localparam int CNT_MAX = (WR_CYCLES > RD_CYCLES)
                         ? ((WR_CYCLES > IMC_CYCLES) ? WR_CYCLES : IMC_CYCLES)
                         : ((RD_CYCLES > IMC_CYCLES) ? RD_CYCLES : IMC_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] IMC_LOAD = CNT_W'(IMC_CYCLES - 1);

  localparam logic [2:0] OP_WRITE = 3'b000;
  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_IMC   = 3'b010;
  localparam logic [2:0] OP_NOP0  = 3'b011;
  localparam logic [2:0] OP_END   = 3'b100;
  localparam logic [2:0] OP_NOP1  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_I, S_EXEC, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic [3:0] addr;
    logic       en_dec;
    logic       mem_en;
    logic       imc_en;
    logic       rw;
    logic       ibuf;
    logic       wbuf;
    logic       sram_rd;
  } strb_t;

  localparam strb_t STRB_IDLE = '{addr: 4'd0, en_dec: 1'b0, mem_en: 1'b0, imc_en: 1'b0,
                                  rw: 1'b1, ibuf: 1'b0, wbuf: 1'b0, sram_rd: 1'b0};

  // Strobe pattern seen by the array for a given (state, instruction) pair.
  function automatic strb_t decode_strobes(input state_t st, input logic [2:0] op,
                                           input logic [3:0] row);
    strb_t s;
    s = STRB_IDLE;
    if (st == S_EXEC) begin
      case (op)
        OP_WRITE: begin
          s.rw = 1'b0; s.mem_en = 1'b1; s.en_dec = 1'b1; s.wbuf = 1'b1; s.addr = row;
        end
        OP_READ: begin
          s.mem_en = 1'b1; s.en_dec = 1'b1; s.sram_rd = 1'b1; s.addr = row;
        end
        OP_IMC: begin
          s.imc_en = 1'b1; s.ibuf = 1'b1;
        end
        default: ;
      endcase
    end
    return s;
  endfunction

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [3:0]       r_row;
  logic             r_err;
  strb_t            r_strb;
  logic             r_rd_en;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_op_nxt;
  logic [3:0]       w_row_nxt;
  logic             w_err_nxt;
  logic             w_advance;
  logic             w_unused_imem;

  // Only the opcode and row fields of the instruction word carry meaning.
  assign w_unused_imem = ^imem_data[28:4];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_row_nxt   = r_row;
    w_err_nxt   = r_err;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pc_nxt    = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_WAIT_I;
      S_WAIT_I: begin
        if (imem_valid) begin
          w_op_nxt  = imem_data[31:29];
          w_row_nxt = imem_data[3:0];
          case (imem_data[31:29])
            OP_WRITE: begin w_cnt_nxt = WR_LOAD;  w_state_nxt = S_EXEC; end
            OP_READ:  begin w_cnt_nxt = RD_LOAD;  w_state_nxt = S_EXEC; end
            OP_IMC:   begin w_cnt_nxt = IMC_LOAD; w_state_nxt = S_EXEC; end
            OP_NOP0, OP_NOP1: w_advance = 1'b1;
            OP_END:   w_state_nxt = S_DONE;
            default: begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_ERR;
            end
          endcase
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) w_advance = 1'b1;
        else             w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // The last address ends the run rather than wrapping to 0.
    if (w_advance) begin
      if (&r_pc) begin
        w_state_nxt = S_DONE;
      end else begin
        w_pc_nxt    = r_pc + PC_W'(1);
        w_state_nxt = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_row   <= '0;
      r_err   <= 1'b0;
      r_strb  <= STRB_IDLE;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_row   <= w_row_nxt;
      r_err   <= w_err_nxt;
      r_strb  <= decode_strobes(w_state_nxt, w_op_nxt, w_row_nxt);
      r_rd_en <= (w_state_nxt == S_FETCH);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign imem_addr           = r_pc;
  assign pc                  = r_pc;
  assign imem_rd_en          = r_rd_en;
  assign address_input       = r_strb.addr;
  assign en_dec              = r_strb.en_dec;
  assign mem_en              = r_strb.mem_en;
  assign imc_en              = r_strb.imc_en;
  assign rw                  = r_strb.rw;
  assign Input_buffer_rd_en  = r_strb.ibuf;
  assign Weight_buffer_rd_en = r_strb.wbuf;
  assign sram_data_rd_enable = r_strb.sram_rd;
  assign busy                = r_busy;
  assign done                = r_done;
  assign err_illegal         = r_err;

endmodule

// File: tb/tb_imc_program_sequencer.sv
// Bench for imc_program_sequencer: a program-level trace model predicts every
// output cycle of a run; directed programs plus randomized programs and latencies.
`timescale 1ns/1ps
module tb_imc_program_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  imem_addr, pc;
  logic        imem_rd_en, imem_valid;
  logic [31:0] imem_data;
  logic [3:0]  address_input;
  logic        en_dec, mem_en, imc_en, rw, Input_buffer_rd_en, Weight_buffer_rd_en;
  logic        sram_data_rd_enable, busy, done, err_illegal;

  imc_program_sequencer #(.PC_W(6), .WR_CYCLES(2), .RD_CYCLES(2), .IMC_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
    .imem_valid(imem_valid), .address_input(address_input), .en_dec(en_dec),
    .mem_en(mem_en), .imc_en(imc_en), .rw(rw), .Input_buffer_rd_en(Input_buffer_rd_en),
    .Weight_buffer_rd_en(Weight_buffer_rd_en), .sram_data_rd_enable(sram_data_rd_enable),
    .busy(busy), .done(done), .err_illegal(err_illegal), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rd_en;
    logic [5:0] addr;
    logic [3:0] row;
    logic       en_dec, mem_en, imc_en, rw, ibuf, wbuf, sram, busy, done, err;
    logic [5:0] pc;
  } obs_t;

  logic [31:0] mem [64];
  obs_t        exp_q [$];
  int          total = 0, bad = 0;
  int          lat = 1, cd = 0, paddr = 0;
  bit          noise = 0, popped = 0;
  int          m_pc = 0;
  bit          m_err = 0;
  int cnt_fetch, cnt_wb, cnt_sram, cnt_imc, cnt_ib, cnt_mem, cnt_done, cnt_any, cnt_row5;

  function automatic obs_t sample();
    obs_t o;
    o = '{rd_en: imem_rd_en, addr: imem_addr, row: address_input, en_dec: en_dec,
          mem_en: mem_en, imc_en: imc_en, rw: rw, ibuf: Input_buffer_rd_en,
          wbuf: Weight_buffer_rd_en, sram: sram_data_rd_enable, busy: busy, done: done,
          err: err_illegal, pc: pc};
    return o;
  endfunction

  function automatic obs_t base(input int p, input bit bsy, input bit e);
    obs_t o;
    o = '0;
    o.addr = 6'(p); o.pc = 6'(p); o.rw = 1'b1; o.busy = bsy; o.err = e;
    return o;
  endfunction

  // Expected cycle-by-cycle picture of one whole run starting at address 0.
  task automatic gen_trace();
    int p = 0;
    bit fin = 0;
    logic [2:0] op;
    logic [3:0] r;
    obs_t o;
    int n;
    m_err = 0;
    while (!fin) begin
      o = base(p, 1, 0); o.rd_en = 1'b1; exp_q.push_back(o);
      o = base(p, 1, 0);
      repeat (lat) exp_q.push_back(o);
      op = mem[p][31:29];
      r  = mem[p][3:0];
      o  = base(p, 1, 0);
      n  = 0;
      case (op)
        3'd0: begin n = 2; o.rw = 0; o.mem_en = 1; o.en_dec = 1; o.wbuf = 1; o.row = r; end
        3'd1: begin n = 2; o.mem_en = 1; o.en_dec = 1; o.sram = 1; o.row = r; end
        3'd2: begin n = 4; o.imc_en = 1; o.ibuf = 1; end
        3'd4: begin o.done = 1; exp_q.push_back(o); fin = 1; end
        3'd5, 3'd6: begin o.err = 1; exp_q.push_back(o); m_err = 1; fin = 1; end
        default: ;
      endcase
      repeat (n) exp_q.push_back(o);
      if (!fin) begin
        if (p == 63) begin
          o = base(p, 1, 0); o.done = 1; exp_q.push_back(o); fin = 1;
        end else p++;
      end
    end
    m_pc = p;
  endtask

  task automatic clear_counts();
    cnt_fetch = 0; cnt_wb = 0; cnt_sram = 0; cnt_imc = 0; cnt_ib = 0;
    cnt_mem = 0; cnt_done = 0; cnt_any = 0; cnt_row5 = 0;
  endtask

  // One clock: answer fetches, then compare the DUT outputs with the model.
  task automatic step();
    obs_t act, ex;
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin imem_valid = 1'b1; imem_data = mem[paddr]; end
    end else if (noise && $urandom_range(0, 3) == 0) begin
      imem_valid = 1'b1; imem_data = $urandom;
    end
    if (imem_rd_en === 1'b1) begin paddr = int'(imem_addr); cd = lat; end
    act = sample();
    popped = 0;
    if (exp_q.size() > 0) begin ex = exp_q.pop_front(); popped = 1; end
    else ex = base(m_pc, 0, m_err);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL trace t=%0t got=%h expected=%h", $time, act, ex);
    end
    cnt_fetch += int'(act.rd_en);  cnt_wb   += int'(act.wbuf);
    cnt_sram  += int'(act.sram);   cnt_imc  += int'(act.imc_en);
    cnt_ib    += int'(act.ibuf);   cnt_mem  += int'(act.mem_en);
    cnt_done  += int'(act.done);
    cnt_any   += int'(act.en_dec | act.mem_en | act.imc_en | act.ibuf | act.wbuf |
                      act.sram | !act.rw | (act.row != 0));
    cnt_row5  += int'(act.en_dec && act.row == 4'd5);
  endtask

  task automatic chk(input string name, input int act, input int ex);
    total++;
    if (act != ex) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, ex);
    end
  endtask

  task automatic run_prog(input int lat_i, input bit strays);
    int guard = 0;
    lat = lat_i;
    clear_counts();
    start = 1'b1;
    gen_trace();
    step();
    start = 1'b0;
    while (exp_q.size() > 0 && guard < 4000) begin
      step();
      start = 1'b0;
      if (strays && popped && $urandom_range(0, 7) == 0) start = 1'b1;
      guard++;
    end
    start = 1'b0;
    step();
    if (exp_q.size() > 0) begin
      chk("run_bound", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic fill_end();
    for (int i = 0; i < 64; i++) mem[i] = 32'h8000_0000;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_data = '0;
    fill_end();
    clear_counts();
    repeat (3) step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_rw", int'(rw), 1);
    chk("reset_pc", int'(pc), 0);
    reset = 1'b1;
    step();

    // WRITE row 5, READ row 5, END
    mem[0] = 32'h0000_0005; mem[1] = 32'h2000_0005; mem[2] = 32'h8000_0000;
    run_prog(1, 0);
    chk("wr_wbuf_cycles", cnt_wb, 2);
    chk("rd_sram_cycles", cnt_sram, 2);
    chk("wrrd_row5_cycles", cnt_row5, 4);
    chk("wrrd_done", cnt_done, 1);
    chk("wrrd_pc", int'(pc), 2);

    // IMC then END with 3-cycle memory latency
    fill_end();
    mem[0] = 32'h4000_0000;
    run_prog(3, 0);
    chk("imc_cycles", cnt_imc, 4);
    chk("imc_ibuf_cycles", cnt_ib, 4);
    chk("imc_mem_en", cnt_mem, 0);
    chk("imc_fetches", cnt_fetch, 2);

    // NOP, NOP, END
    fill_end();
    mem[0] = 32'h6000_0000; mem[1] = 32'hE000_0000;
    run_prog(1, 0);
    chk("nop_strobes", cnt_any, 0);
    chk("nop_fetches", cnt_fetch, 3);
    chk("nop_pc", int'(pc), 2);
    chk("nop_done", cnt_done, 1);

    // WRITE row 1 then an illegal opcode; a fresh start clears the flag
    fill_end();
    mem[0] = 32'h0000_0001; mem[1] = 32'hA000_0000;
    run_prog(1, 0);
    chk("ill_wbuf", cnt_wb, 2);
    chk("ill_err", int'(err_illegal), 1);
    chk("ill_no_done", cnt_done, 0);
    chk("ill_idle", int'(busy), 0);
    fill_end();
    run_prog(2, 0);
    chk("ill_cleared", int'(err_illegal), 0);
    chk("ill_then_done", cnt_done, 1);

    // 64 WRITEs and no END: stops at the last address, stray starts ignored
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000 | 32'(i % 16);
    run_prog(1, 1);
    chk("fill_fetches", cnt_fetch, 64);
    chk("fill_wbuf", cnt_wb, 128);
    chk("fill_done", cnt_done, 1);
    chk("fill_pc", int'(pc), 63);

    // Reset held for three cycles in the middle of an IMC op
    fill_end();
    mem[0] = 32'h4000_0000;
    lat = 1;
    start = 1'b1; gen_trace(); step(); start = 1'b0;
    step(); step(); step();
    chk("rst_mid_imc_active", int'(imc_en), 1);
    reset = 1'b0;
    exp_q.delete(); m_pc = 0; m_err = 0; cd = 0;
    step();
    chk("rst_imc_off", int'(imc_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_rw", int'(rw), 1);
    step();
    start = 1'b1;
    step();
    reset = 1'b1; start = 1'b0;
    step();
    chk("rst_start_ignored", int'(busy), 0);

    // Randomized programs, latencies, bus noise and stray starts
    noise = 1;
    for (int t = 0; t < 40; t++) begin
      int len;
      logic [2:0] op;
      fill_end();
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: op = 3'd0;
          3, 4:    op = 3'd1;
          5, 6:    op = 3'd2;
          7:       op = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd7;
          8:       op = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'd3;
          default: op = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'd4;
        endcase
        mem[i] = {op, 25'($urandom), 4'($urandom_range(0, 15))};
      end
      run_prog($urandom_range(1, 4), 1);
      repeat ($urandom_range(0, 3)) step();
    end
    noise = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
